// File: rtl/combat_pkg.sv
// combat_pkg: shared state and winner encodings for the combat resolver
package combat_pkg;
    typedef enum logic [1:0] {FIGHT, KO, OVER} state_t;
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1 = 2'b01;
    localparam logic [1:0] WIN_P2 = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;
    localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/combat_resolver_invuln_timer.sv
// invuln_timer: per-player invincibility frame counter, reload beats decrement
module invuln_timer #(
    parameter int INVULN_FRAMES = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic load,
    input  logic freeze,
    input  logic clr,
    output logic active
);
    localparam int CW = $clog2(INVULN_FRAMES + 1);
    logic [CW-1:0] count_q, count_d;
    always_comb begin
        count_d = clr ? '0 : load ? CW'(INVULN_FRAMES) :
                  (tick && !freeze && count_q != '0) ? count_q - 1'b1 : count_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else count_q <= count_d;
    end
    assign active = count_q != '0;
endmodule

// File: rtl/combat_resolver.sv
// combat_resolver: frame-quantised hit resolution, health, KO hold and winner
module combat_resolver import combat_pkg::*; #(
    parameter int MAX_HEALTH = 400,
    parameter int DAMAGE = 100,
    parameter int HEALTH_W = 11,
    parameter int INVULN_FRAMES = 60,
    parameter int KO_FRAMES = 120,
    parameter int BAR_RIGHT = 639
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                v_sync,
    input  logic                p1_hit,
    input  logic                p2_hit,
    input  logic                restart,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic [HEALTH_W-1:0] p2_bar_xpos,
    output logic                p1_invuln,
    output logic                p2_invuln,
    output logic                game_over,
    output logic [1:0]          winner
);
    localparam int KW = $clog2(KO_FRAMES + 1);
    localparam logic signed [HEALTH_W-1:0] H_MAX = HEALTH_W'(MAX_HEALTH);
    localparam logic signed [HEALTH_W-1:0] H_DMG = HEALTH_W'(DAMAGE);
    // top bit of each shift chain holds the previous synchronised value for edge detection
    logic [SYNC_STAGES:0] vs_q, vs_d, rs_q, rs_d;
    state_t state_q, state_d;
    logic signed [HEALTH_W-1:0] h1_q, h1_d, h2_q, h2_d;
    logic pend1_q, pend1_d, pend2_q, pend2_d;
    logic [1:0] win_q, win_d;
    logic [KW-1:0] ko_q, ko_d;
    logic tick, restart_edge, fight, res1, res2, inv1, inv2;
    always_comb begin
        vs_d = {vs_q[SYNC_STAGES-1:0], v_sync};
        rs_d = {rs_q[SYNC_STAGES-1:0], restart};
        tick = vs_q[SYNC_STAGES] && !vs_q[SYNC_STAGES-1];
        restart_edge = rs_q[SYNC_STAGES-1] && !rs_q[SYNC_STAGES];
        fight = state_q == FIGHT;
        res1 = fight && tick && pend1_q;
        res2 = fight && tick && pend2_q;
        h1_d = res1 ? ((h1_q <= H_DMG) ? '0 : h1_q - H_DMG) : h1_q;
        h2_d = res2 ? ((h2_q <= H_DMG) ? '0 : h2_q - H_DMG) : h2_q;
        pend1_d = !tick && fight && (pend1_q || (p1_hit && !inv1));
        pend2_d = !tick && fight && (pend2_q || (p2_hit && !inv2));
        state_d = state_q;
        win_d = win_q;
        ko_d = ko_q;
        if (fight && tick && (h1_d == '0 || h2_d == '0)) begin
            state_d = KO;
            ko_d = KW'(KO_FRAMES);
            win_d = (h1_d == '0 && h2_d == '0) ? WIN_DRAW : (h2_d == '0) ? WIN_P1 : WIN_P2;
        end else if (state_q == KO && tick) begin
            ko_d = ko_q - 1'b1;
            state_d = (ko_q == KW'(1)) ? OVER : KO;
        end
        if (restart_edge) begin
            state_d = FIGHT;
            h1_d = H_MAX;
            h2_d = H_MAX;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            win_d = WIN_NONE;
            ko_d = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q <= '0;
            rs_q <= '0;
            state_q <= FIGHT;
            h1_q <= H_MAX;
            h2_q <= H_MAX;
            pend1_q <= 1'b0;
            pend2_q <= 1'b0;
            win_q <= WIN_NONE;
            ko_q <= '0;
        end else begin
            vs_q <= vs_d;
            rs_q <= rs_d;
            state_q <= state_d;
            h1_q <= h1_d;
            h2_q <= h2_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            win_q <= win_d;
            ko_q <= ko_d;
        end
    end
    invuln_timer #(.INVULN_FRAMES(INVULN_FRAMES)) u_inv1 (
        .clk(clk), .rst(rst), .tick(tick), .load(res1), .freeze(!fight), .clr(restart_edge), .active(inv1)
    );
    invuln_timer #(.INVULN_FRAMES(INVULN_FRAMES)) u_inv2 (
        .clk(clk), .rst(rst), .tick(tick), .load(res2), .freeze(!fight), .clr(restart_edge), .active(inv2)
    );
    assign p1_health = h1_q;
    assign p2_health = h2_q;
    assign p2_bar_xpos = HEALTH_W'(BAR_RIGHT) - h2_q;
    assign p1_invuln = inv1;
    assign p2_invuln = inv2;
    assign game_over = state_q != FIGHT;
    assign winner = win_q;
endmodule
